tagged_stream_router_8: RTL and testbench
=========================================

Name: tagged_stream_router_8

Overview:
- Drain-side companion to the 8-lane tagged input FIFO bank. That bank stores {branch tag[2:0], payload} per lane.
- This block reads the heads of the 8 lane streams and routes each word to the output branch named by its tag.
- Each output branch has its own round-robin arbiter, a one-word output register and a valid/ready handshake.
- Sits between the per-lane FIFOs and the 8 branch consumers.

Parameters:
- WIDTH, 16, payload width in bits; the lane word is WIDTH+3 bits.
- LANES, 8, number of lanes and branches; fixed at 8, tag is 3 bits.

Ports:
- i_clock  input  1  single clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_in_data  input  8*(WIDTH+3)  lane l word at [l*(WIDTH+3) +: WIDTH+3]; bits [WIDTH+2:WIDTH] are the tag, [WIDTH-1:0] the payload.
- i_in_valid  input  8  lane l head valid.
- o_in_ready  output  8  lane l head consumed this cycle.
- o_out_data  output  8*WIDTH  branch b payload at [b*WIDTH +: WIDTH].
- o_out_src  output  8*3  branch b source lane id at [b*3 +: 3].
- o_out_valid  output  8  branch b output register holds a word.
- i_out_ready  input  8  branch b consumer accepts.
- o_grant_count  output  8*16  per-branch count of accepted words, wraps at 2^16.

Behaviour:
- Reset (i_reset=0, asynchronous assert, synchronous deassert edge):
  - o_out_valid=0, o_out_data=0, o_out_src=0, o_grant_count=0.
  - All round-robin pointers rr[b]=0.
  - Words held in output registers are discarded.
  - o_in_ready=0 while reset is asserted.
- Request: lane l requests branch b when i_in_valid[l]=1 and tag(l)=b. Each lane requests exactly one branch, so arbiters never contend for a lane.
- Branch b can load when o_out_valid[b]=0, or when o_out_valid[b]=1 and i_out_ready[b]=1 (same-cycle drain and refill allowed, no bubble).
- Arbitration for branch b:
  - Among requesting lanes, grant the first lane found scanning from rr[b] upward, modulo 8.
  - Grant only when the branch can load.
  - On grant g: rr[b] <= (g+1) mod 8.
  - No grant: rr[b] unchanged.
- o_in_ready[l] is combinational: 1 iff lane l is granted this cycle. It may depend on i_in_valid; this is permitted by the lane FIFO handshake. o_in_ready[l]=0 when i_in_valid[l]=0.
- Next edge on grant g to branch b: o_out_data[b] <= payload(g), o_out_src[b] <= g, o_out_valid[b] <= 1, o_grant_count[b] += 1.
- Latency: one cycle from lane accept to o_out_valid.
- Full throughput: one word per branch per cycle; up to 8 words total per cycle when all tags are distinct.
- Drain without refill: o_out_valid[b] <= 0; data and src hold their last values.
- Backpressure: while o_out_valid[b]=1 and i_out_ready[b]=0, the register holds stable and every lane tagged b sees o_in_ready=0. Other branches are unaffected (no head-of-line blocking across branches).
- Ordering: words from one lane leave in acceptance order. A lane's head blocks that lane until its branch grants.
- Fairness: with N persistent requesters on one branch, each is granted exactly once per N grants.
- Counter wrap: 16'hFFFF + 1 -> 16'h0000.

Test Plan:
1. Reset, then lane 3 presents tag=5, payload=16'hA5A5, i_out_ready=all 1 -> o_in_ready[3]=1 that cycle. Next cycle o_out_valid[5]=1, data=16'hA5A5, src=3, o_grant_count[5]=1. All other o_out_valid=0.
2. Lanes 0,2,7 hold tag=1 continuously, i_out_ready[1]=1 -> o_out_src[1] sequence 0,2,7,0,2,7. A new word every cycle, no bubbles.
3. Lanes 0..7 carry tags 7..0 simultaneously -> next cycle all 8 o_out_valid=1, branch b src=7-b. Each o_grant_count=1.
4. Branch 4 full with i_out_ready[4]=0 for 5 cycles, lane 1 tagged 4, lane 2 tagged 6 -> o_in_ready[1]=0 for those 5 cycles. Branch 4 output stays stable. Lane 2 words flow to branch 6 each cycle. After i_out_ready[4]=1, lane 1 is granted in that same cycle.
5. Reset pulse asserted mid-stream with branches 0 and 3 valid -> o_out_valid immediately 0 (asynchronous), counts 0. After release, rr restarts at 0: lanes 5 and 6 both tagged 0 -> lane 5 granted first.
6. Stream 65537 words to branch 2 -> o_grant_count[2]=1 after wrap.

Source files
------------

// File: rtl/tagged_stream_router_8.sv
`default_nettype none
// tagged_stream_router_8: routes tagged lane-head words to 8 output branches.
// Each branch has its own round-robin arbiter and a one-word output register.
module tagged_stream_router_8 #(
  parameter int WIDTH = 16,
  parameter int LANES = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [LANES*(WIDTH+3)-1:0] i_in_data,
  input  logic [LANES-1:0]           i_in_valid,
  output logic [LANES-1:0]           o_in_ready,
  output logic [LANES*WIDTH-1:0]     o_out_data,
  output logic [LANES*3-1:0]         o_out_src,
  output logic [LANES-1:0]           o_out_valid,
  input  logic [LANES-1:0]           i_out_ready,
  output logic [LANES*16-1:0]        o_grant_count
);

  localparam int WORD = WIDTH + 3;

  logic [2:0]       lane_tag     [LANES];
  logic [WIDTH-1:0] lane_payload [LANES];
  logic [LANES-1:0] grant_valid;
  logic [2:0]       grant_lane   [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_tag[l]     = i_in_data[l*WORD+WIDTH +: 3];
    assign lane_payload[l] = i_in_data[l*WORD +: WIDTH];
  end

  for (genvar b = 0; b < LANES; b++) begin : g_branch
    logic [2:0]       rr;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [2:0]       out_src_reg;
    logic [15:0]      count_reg;
    logic             can_load;
    logic             found;
    logic [2:0]       pick;
    logic [2:0]       idx;

    // A full register may still load when it drains in the same cycle.
    assign can_load = !out_valid_reg || i_out_ready[b];

    always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      idx   = 3'd0;
      for (int k = 0; k < LANES; k++) begin
        idx = rr + 3'(k);
        if (!found && i_in_valid[idx] && (lane_tag[idx] == 3'(b))) begin
          found = 1'b1;
          pick  = idx;
        end
      end
    end

    assign grant_valid[b] = found && can_load;
    assign grant_lane[b]  = pick;

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        rr            <= 3'd0;
        out_valid_reg <= 1'b0;
        out_data_reg  <= '0;
        out_src_reg   <= 3'd0;
        count_reg     <= 16'd0;
      end else if (grant_valid[b]) begin
        rr            <= pick + 3'd1;
        out_valid_reg <= 1'b1;
        out_data_reg  <= lane_payload[pick];
        out_src_reg   <= pick;
        count_reg     <= count_reg + 16'd1;
      end else if (i_out_ready[b]) begin
        out_valid_reg <= 1'b0;
      end
    end

    assign o_out_valid[b]                = out_valid_reg;
    assign o_out_data[b*WIDTH +: WIDTH]  = out_data_reg;
    assign o_out_src[b*3 +: 3]           = out_src_reg;
    assign o_grant_count[b*16 +: 16]     = count_reg;
  end

  // A lane requests only the branch named by its tag, so one lookup suffices.
  always_comb begin
    o_in_ready = '0;
    for (int l = 0; l < LANES; l++) begin
      if (i_reset && i_in_valid[l] && grant_valid[lane_tag[l]] &&
          (grant_lane[lane_tag[l]] == 3'(l)))
        o_in_ready[l] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tagged_stream_router_8.sv
`default_nettype none
// tb_tagged_stream_router_8: directed self-checking bench for tagged_stream_router_8.
module tb_tagged_stream_router_8;

  localparam int WIDTH = 16;
  localparam int LANES = 8;
  localparam int WORD  = WIDTH + 3;

  logic                       clk;
  logic                       rst_n;
  logic [LANES*WORD-1:0]      in_data;
  logic [LANES-1:0]           in_valid;
  logic [LANES-1:0]           in_ready;
  logic [LANES*WIDTH-1:0]     out_data;
  logic [LANES*3-1:0]         out_src;
  logic [LANES-1:0]           out_valid;
  logic [LANES-1:0]           out_ready;
  logic [LANES*16-1:0]        grant_count;

  int checks = 0;
  int errors = 0;

  tagged_stream_router_8 #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_in_data     (in_data),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .o_out_data    (out_data),
    .o_out_src     (out_src),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_grant_count (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [2:0] tag, input logic [WIDTH-1:0] payload);
    in_data[l*WORD +: WORD] = {tag, payload};
  endtask

  function automatic logic [31:0] od(input int b);
    return 32'(out_data[b*WIDTH +: WIDTH]);
  endfunction

  function automatic logic [31:0] os(input int b);
    return 32'(out_src[b*3 +: 3]);
  endfunction

  function automatic logic [31:0] oc(input int b);
    return 32'(grant_count[b*16 +: 16]);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    logic [2:0] exp_src [6];
    exp_src = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2, 3'd7};

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = '1;

    // Reset state, with requests presented while reset is held
    #12;
    for (int l = 0; l < LANES; l++) set_lane(l, 3'(l), 16'h1111);
    in_valid = 8'hFF;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out_data_zero", 32'(|out_data), 32'h0);
    check("reset_out_src_zero", 32'(|out_src), 32'h0);
    check("reset_count_zero", 32'(|grant_count), 32'h0);
    in_valid = '0;
    in_data  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // 1: single word lane 3 -> branch 5
    set_lane(3, 3'd5, 16'hA5A5);
    in_valid = 8'h08;
    #1;
    check("t1_in_ready", 32'(in_ready), 32'h08);
    next_cycle();
    check("t1_out_valid", 32'(out_valid), 32'h20);
    check("t1_data5", od(5), 32'hA5A5);
    check("t1_src5", os(5), 32'd3);
    check("t1_count5", oc(5), 32'd1);

    // 2: lanes 0,2,7 share branch 1; round-robin, no bubbles
    in_valid = '0;
    set_lane(0, 3'd1, 16'h0000);
    set_lane(2, 3'd1, 16'h0002);
    set_lane(7, 3'd1, 16'h0007);
    in_valid = 8'h85;
    #1;
    check("t2_first_in_ready", 32'(in_ready), 32'h01);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      check($sformatf("t2_valid1_%0d", i), 32'(out_valid[1]), 32'd1);
      check($sformatf("t2_src1_%0d", i), os(1), 32'(exp_src[i]));
    end
    check("t2_count1", oc(1), 32'd6);
    in_valid = '0;
    next_cycle();
    check("t2_drained", 32'(out_valid), 32'h0);

    // 3: all lanes, distinct tags, fresh counters
    reset_pulse();
    for (int l = 0; l < LANES; l++) set_lane(l, 3'(7 - l), 16'(16'h0100 + l));
    in_valid = 8'hFF;
    #1;
    check("t3_in_ready", 32'(in_ready), 32'hFF);
    next_cycle();
    check("t3_out_valid", 32'(out_valid), 32'hFF);
    for (int b = 0; b < LANES; b++) begin
      check($sformatf("t3_src%0d", b), os(b), 32'(7 - b));
      check($sformatf("t3_data%0d", b), od(b), 32'(16'h0100 + (7 - b)));
      check($sformatf("t3_count%0d", b), oc(b), 32'd1);
    end

    // 4: branch 4 backpressured, branch 6 keeps flowing
    in_valid  = '0;
    out_ready = 8'hEF;
    set_lane(1, 3'd4, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      set_lane(2, 3'd6, 16'(16'h6000 + i));
      in_valid = 8'h06;
      #1;
      check($sformatf("t4_ready1_%0d", i), 32'(in_ready[1]), 32'd0);
      check($sformatf("t4_ready2_%0d", i), 32'(in_ready[2]), 32'd1);
      next_cycle();
      check($sformatf("t4_valid4_%0d", i), 32'(out_valid[4]), 32'd1);
      check($sformatf("t4_data4_%0d", i), od(4), 32'h0103);
      check($sformatf("t4_src4_%0d", i), os(4), 32'd3);
      check($sformatf("t4_data6_%0d", i), od(6), 32'(16'h6000 + i));
      check($sformatf("t4_src6_%0d", i), os(6), 32'd2);
    end
    set_lane(2, 3'd6, 16'h6005);
    out_ready = 8'hFF;
    #1;
    check("t4_release_ready1", 32'(in_ready[1]), 32'd1);
    next_cycle();
    check("t4_release_data4", od(4), 32'hBEEF);
    check("t4_release_src4", os(4), 32'd1);
    check("t4_count4", oc(4), 32'd2);
    check("t4_data6_last", od(6), 32'h6005);
    check("t4_count6", oc(6), 32'd7);
    in_valid = '0;
    next_cycle();
    check("t4_drained", 32'(out_valid), 32'h0);

    // 5: asynchronous reset with branches 0 and 3 holding words
    out_ready = 8'h00;
    set_lane(0, 3'd0, 16'h0A0A);
    set_lane(1, 3'd3, 16'h3B3B);
    in_valid = 8'h03;
    next_cycle();
    check("t5_pre_valid", 32'(out_valid), 32'h09);
    in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'h0);
    check("t5_async_count", 32'(|grant_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    out_ready = 8'hFF;
    set_lane(5, 3'd0, 16'h0505);
    set_lane(6, 3'd0, 16'h0606);
    in_valid = 8'h60;
    #1;
    check("t5_first_ready", 32'(in_ready), 32'h20);
    next_cycle();
    check("t5_first_src", os(0), 32'd5);
    check("t5_second_ready", 32'(in_ready), 32'h40);
    next_cycle();
    check("t5_second_src", os(0), 32'd6);
    in_valid = '0;
    next_cycle();

    // 6: counter wrap on branch 2
    set_lane(0, 3'd2, 16'h2222);
    in_valid = 8'h01;
    repeat (65536) @(posedge clk);
    #1;
    check("t6_count_at_wrap", oc(2), 32'd0);
    next_cycle();
    check("t6_count_after_wrap", oc(2), 32'd1);
    check("t6_valid2", 32'(out_valid[2]), 32'd1);
    in_valid = '0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
